// File: rtl/par_to_ser.sv
// ---------------------------------------------------------------------------
// par_to_ser
//   Parallel-to-serial converter. A word captured on the load strobe is shifted
//   out MSB first, one bit per clock, on a registered serial line that rests
//   at 0 when idle. The producer owns load timing; a load in any state
//   restarts the output with the new word on the next cycle.
//
// Parameters
//   SERIAL_LEN   bits per word (>= 2), also the width of parallel_in
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset (overrides load)
//   load         capture strobe
//   parallel_in  word to send, only looked at while load=1
//   serial_out   registered serial data, MSB first, 0 when idle
// ---------------------------------------------------------------------------
module par_to_ser #(
   parameter int SERIAL_LEN = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [SERIAL_LEN-1:0] parallel_in,
   output logic                  serial_out
);

   localparam int CW = (SERIAL_LEN > 2) ? $clog2(SERIAL_LEN) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t                state_reg,  state_next;
   logic [SERIAL_LEN-1:0] shreg_reg,  shreg_next;
   logic [CW-1:0]         cnt_reg,    cnt_next;
   logic                  serial_reg, serial_next;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         shreg_reg  <= '0;
         cnt_reg    <= '0;
         serial_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         shreg_reg  <= shreg_next;
         cnt_reg    <= cnt_next;
         serial_reg <= serial_next;
      end
   end

   // Next-state and datapath logic.
   // The bit shown on serial_out is always the top bit of shreg_reg, so each
   // shift step presents the bit just below it and moves the register left.
   // cnt_reg counts the bits still to be shown after the current one.
   always_comb begin
      state_next  = state_reg;
      shreg_next  = shreg_reg;
      cnt_next    = cnt_reg;
      serial_next = serial_reg;

      if (load) begin
         // A load restarts from any state; an in-flight word is dropped.
         state_next  = SHIFT;
         shreg_next  = parallel_in;
         cnt_next    = CW'(SERIAL_LEN - 1);
         serial_next = parallel_in[SERIAL_LEN-1];
      end else begin
         case (state_reg)
            IDLE: begin
               serial_next = 1'b0;
            end
            SHIFT: begin
               if (cnt_reg == '0) begin
                  // bit 0 has had its cycle: return the line to rest
                  state_next  = IDLE;
                  shreg_next  = '0;
                  serial_next = 1'b0;
               end else begin
                  cnt_next    = cnt_reg - CW'(1);
                  serial_next = shreg_reg[SERIAL_LEN-2];
                  shreg_next  = {shreg_reg[SERIAL_LEN-2:0], 1'b0};
               end
            end
            default: begin
               state_next  = IDLE;
               serial_next = 1'b0;
            end
         endcase
      end
   end

   assign serial_out = serial_reg;

endmodule

// File: tb/tb_par_to_ser.sv
// ---------------------------------------------------------------------------
// tb_par_to_ser
//   Directed bench for par_to_ser (SERIAL_LEN = 8). Each test pushes the
//   serial stream it expects onto a queue, then steps the clock one cycle at
//   a time; after every edge the oldest expected bit is popped and compared
//   with serial_out.
// ---------------------------------------------------------------------------
module tb_par_to_ser;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         load;
   logic [N-1:0] parallel_in;
   logic         serial_out;

   logic exp_q[$];
   int   checks = 0;
   int   errors = 0;

   par_to_ser #(.SERIAL_LEN(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load),
      .parallel_in (parallel_in),
      .serial_out  (serial_out)
   );

   always #5 clk = ~clk;

   // Expected stream of one word, MSB first
   task automatic push_word(input logic [N-1:0] w);
      for (int i = N - 1; i >= 0; i--) exp_q.push_back(w[i]);
   endtask

   task automatic push_bit(input logic b, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(b);
   endtask

   // Drive one cycle of inputs, take the edge, then check serial_out
   task automatic tick(input string tag, input logic r, input logic ld,
                       input logic [N-1:0] d);
      logic exp_bit;
      rst_n       = r;
      load        = ld;
      parallel_in = d;
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s: serial_out=%b but no expected value queued", tag, serial_out);
      end else begin
         exp_bit = exp_q.pop_front();
         assert (serial_out === exp_bit) else begin
            errors++;
            $error("FAIL %s: serial_out=%b expected=%b", tag, serial_out, exp_bit);
         end
      end
   endtask

   // idle cycles with parallel_in left undriven to show it is ignored
   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) tick(tag, 1'b1, 1'b0, 'x);
   endtask

   initial begin
      rst_n       = 1'b0;
      load        = 1'b1;
      parallel_in = 8'hFF;

      // 1. Reset holds the line at 0 even with load asserted
      push_bit(1'b0, 3);
      for (int i = 0; i < 3; i++) tick("reset", 1'b0, 1'b1, 8'hFF);
      push_bit(1'b0, 2);
      idle("post_reset", 2);

      // 2. Single word A5 then rest
      push_word(8'hA5);
      push_bit(1'b0, 1);
      tick("single", 1'b1, 1'b1, 8'hA5);
      idle("single", 8);

      // 3. Back-to-back FF then 01 with no gap
      push_word(8'hFF);
      push_word(8'h01);
      push_bit(1'b0, 1);
      tick("b2b", 1'b1, 1'b1, 8'hFF);
      idle("b2b", 7);
      tick("b2b", 1'b1, 1'b1, 8'h01);
      idle("b2b", 8);

      // 4. Abort F0 after three bits with 0F
      push_bit(1'b1, 3);
      push_word(8'h0F);
      push_bit(1'b0, 1);
      tick("abort", 1'b1, 1'b1, 8'hF0);
      idle("abort", 2);
      tick("abort", 1'b1, 1'b1, 8'h0F);
      idle("abort", 8);

      // 5. Reset mid-word (with load asserted), then a fresh word 80
      push_bit(1'b1, 4);
      push_bit(1'b0, 1);
      push_word(8'h80);
      push_bit(1'b0, 1);
      tick("rst_mid", 1'b1, 1'b1, 8'hFF);
      idle("rst_mid", 3);
      tick("rst_mid", 1'b0, 1'b1, 8'hFF);
      tick("rst_mid", 1'b1, 1'b1, 8'h80);
      idle("rst_mid", 8);

      // 6. Load held for three cycles: 80, 00, 81
      push_bit(1'b1, 1);
      push_bit(1'b0, 1);
      push_word(8'h81);
      push_bit(1'b0, 1);
      tick("held", 1'b1, 1'b1, 8'h80);
      tick("held", 1'b1, 1'b1, 8'h00);
      tick("held", 1'b1, 1'b1, 8'h81);
      idle("held", 8);

      // Every expected bit must have been consumed
      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL queue_empty: leftover=%0d expected=0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
